// File: rtl/l3_canonicalizer.sv
// Reduces a redundant_poly_L3 word (signed per-limb carries) to its canonical residue in [0, MOD).
// din limb i occupies din[i*(LIMB_W+CARRY_W) +: LIMB_W+CARRY_W] as {carry[CARRY_W-1:0], val[LIMB_W-1:0]}.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// PROP  | carry propagation, one limb per cycle
// CORR  | one +/-MOD correction (or range check) per cycle
// DONE  | result held on dout/err/ncorr until out_ready
module l3_canonicalizer #(
    parameter int N_LIMB   = 4,
    parameter int LIMB_W   = 64,
    parameter int CARRY_W  = 8,
    parameter logic [N_LIMB*LIMB_W-1:0] MOD =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
    parameter int MAX_CORR = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N_LIMB*(LIMB_W+CARRY_W)-1:0]   din,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [N_LIMB*LIMB_W-1:0]             dout,
    output logic                                 err,
    output logic [3:0]                           ncorr
);

    localparam int LW    = LIMB_W + CARRY_W;
    localparam int VW    = N_LIMB * LIMB_W;
    localparam int CW    = CARRY_W + 2;
    localparam int AW    = VW + CW;
    localparam int SW    = LIMB_W + CW;
    localparam int CNT_W = (N_LIMB > 1) ? $clog2(N_LIMB) : 1;
    localparam logic [AW-1:0] MOD_EXT = {{CW{1'b0}}, MOD};

    typedef enum logic [1:0] {IDLE, PROP, CORR, DONE} state_t;

    state_t                         state;
    logic [N_LIMB-1:0][LW-1:0]      din_q;
    logic [CNT_W-1:0]               cnt;
    logic [CW-1:0]                  carry_q;
    logic [AW-1:0]                  acc;

    logic [LIMB_W-1:0]              val_k;
    logic [CARRY_W-1:0]             carry_k;
    logic [SW-1:0]                  s;
    logic [CW-1:0]                  c_next;
    logic                           acc_neg;
    logic                           acc_ge;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dout      = acc[VW-1:0];

    // s is wide enough that its bits above LIMB_W are exactly (val + c_prev) >>> LIMB_W
    always_comb begin
        val_k   = din_q[cnt][LIMB_W-1:0];
        carry_k = din_q[cnt][LW-1:LIMB_W];
        s       = {{(SW-LIMB_W){1'b0}}, val_k} + {{(SW-CW){carry_q[CW-1]}}, carry_q};
        c_next  = s[SW-1:LIMB_W] + {{(CW-CARRY_W){carry_k[CARRY_W-1]}}, carry_k};
        acc_neg = acc[AW-1];
        acc_ge  = !acc_neg && (acc >= MOD_EXT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            din_q   <= '0;
            cnt     <= '0;
            carry_q <= '0;
            acc     <= '0;
            err     <= 1'b0;
            ncorr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        din_q   <= din;
                        cnt     <= '0;
                        carry_q <= '0;
                        acc     <= '0;
                        err     <= 1'b0;
                        ncorr   <= '0;
                        state   <= PROP;
                    end
                end
                PROP: begin
                    acc[int'(cnt)*LIMB_W +: LIMB_W] <= s[LIMB_W-1:0];
                    if (cnt == CNT_W'(N_LIMB-1)) begin
                        acc[AW-1 -: CW] <= c_next;
                        state           <= CORR;
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        carry_q <= c_next;
                    end
                end
                CORR: begin
                    if (!acc_neg && !acc_ge) begin
                        err   <= 1'b0;
                        state <= DONE;
                    end else if (ncorr == 4'(MAX_CORR)) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        acc   <= acc_neg ? (acc + MOD_EXT) : (acc - MOD_EXT);
                        ncorr <= ncorr + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l3_canonicalizer.sv
// Directed bench for l3_canonicalizer: values, latency, backpressure and reset abort.
module tb_l3_canonicalizer;

    localparam logic [255:0] MOD =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [287:0] din;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] dout;
    logic         err;
    logic [3:0]   ncorr;

    int n_checks = 0;
    int n_fail   = 0;

    l3_canonicalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .err       (err),
        .ncorr     (ncorr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [287:0] mk(input logic [63:0] v0, input logic [63:0] v1,
                                        input logic [63:0] v2, input logic [63:0] v3,
                                        input logic [7:0] c0, input logic [7:0] c1,
                                        input logic [7:0] c2, input logic [7:0] c3);
        return {c3, v3, c2, v2, c1, v1, c0, v0};
    endfunction

    function automatic logic [287:0] plain(input logic [255:0] v);
        return mk(v[63:0], v[127:64], v[191:128], v[255:192], 8'h0, 8'h0, 8'h0, 8'h0);
    endfunction

    // Accept one word, scramble din afterwards, return cycles from accept edge to out_valid.
    task automatic send_word(input logic [287:0] d, output int lat);
        @(negedge clk);
        din      = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din      = '1;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_word();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        n_checks++;
        if (dout !== 256'd0 || err !== 1'b0 || ncorr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_out: dout=%h err=%b ncorr=%0d, required 0/0/0", dout, err, ncorr);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        send_word(mk(64'd1, 0, 0, 0, 8'h0, 8'h0, 8'h0, 8'h0), lat);
        n_checks++;
        if (lat !== 5 || dout !== 256'd1 || err !== 1'b0 || ncorr !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_one: lat=%0d dout=%h err=%b ncorr=%0d, required 5/1/0/0", lat, dout, err, ncorr);
        end
        release_word();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end

        send_word(mk(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 8'h01, 8'h0, 8'h0, 8'h0), lat);
        n_checks++;
        if (lat !== 5 || dout !== 256'h1_FFFF_FFFF_FFFF_FFFF || ncorr !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_carry: lat=%0d dout=%h ncorr=%0d, required 5/1ffffffffffffffff/0", lat, dout, ncorr);
        end
        release_word();

        // negative carry in limb1 cancelled by limb2: V = 5
        send_word(mk(64'd5, 64'd0, 64'd1, 64'd0, 8'h00, 8'hFF, 8'h00, 8'h00), lat);
        n_checks++;
        if (lat !== 5 || dout !== 256'd5 || err !== 1'b0 || ncorr !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_negcarry: lat=%0d dout=%h err=%b ncorr=%0d, required 5/5/0/0", lat, dout, err, ncorr);
        end
        release_word();
    endtask

    task automatic test_boundary();
        int lat;
        logic [255:0] exp_v;
        exp_v = MOD - 256'd1;
        send_word(plain(exp_v), lat);
        n_checks++;
        if (lat !== 5 || dout !== exp_v || ncorr !== 4'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL bnd_modm1: lat=%0d dout=%h ncorr=%0d err=%b, required 5/%h/0/0", lat, dout, ncorr, err, exp_v);
        end
        release_word();

        send_word(plain(MOD), lat);
        n_checks++;
        if (lat !== 6 || dout !== 256'd0 || ncorr !== 4'd1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL bnd_mod: lat=%0d dout=%h ncorr=%0d err=%b, required 6/0/1/0", lat, dout, ncorr, err);
        end
        release_word();

        exp_v = MOD - (256'd1 << 64);
        send_word(mk(64'd0, 0, 0, 0, 8'hFF, 8'h0, 8'h0, 8'h0), lat);
        n_checks++;
        if (lat !== 6 || dout !== exp_v || ncorr !== 4'd1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL bnd_neg2p64: lat=%0d dout=%h ncorr=%0d err=%b, required 6/%h/1/0", lat, dout, ncorr, err, exp_v);
        end
        release_word();

        exp_v = MOD - 256'd1;
        send_word(mk(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 8'hFF, 8'h0, 8'h0, 8'h0), lat);
        n_checks++;
        if (lat !== 6 || dout !== exp_v || ncorr !== 4'd1) begin
            n_fail++;
            $display("FAIL bnd_minus1: lat=%0d dout=%h ncorr=%0d, required 6/%h/1", lat, dout, ncorr, exp_v);
        end
        release_word();

        exp_v = MOD + MOD + 256'd5;
        send_word(plain(exp_v), lat);
        n_checks++;
        if (lat !== 7 || dout !== 256'd5 || ncorr !== 4'd2 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL bnd_2mod5: lat=%0d dout=%h ncorr=%0d err=%b, required 7/5/2/0", lat, dout, ncorr, err);
        end
        release_word();
    endtask

    task automatic test_saturation();
        int lat;
        send_word(mk(64'd0, 0, 0, 0, 8'h0, 8'h0, 8'h0, 8'h7F), lat);
        n_checks++;
        if (lat !== 13 || err !== 1'b1 || ncorr !== 4'd8) begin
            n_fail++;
            $display("FAIL sat_err: lat=%0d err=%b ncorr=%0d, required 13/1/8", lat, err, ncorr);
        end
        release_word();
    endtask

    task automatic test_back_to_back();
        int lat;
        send_word(plain(256'd42), lat);
        n_checks++;
        if (lat !== 5 || dout !== 256'd42) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d dout=%h, required 5/2a", lat, dout);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            din      = plain(256'd99);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dout !== 256'd42 || ncorr !== 4'd0) begin
                n_fail++;
                $display("FAIL b2b_hold%0d: out_valid=%b in_ready=%b dout=%h ncorr=%0d, required 1/0/2a/0",
                         i, out_valid, in_ready, dout, ncorr);
            end
        end
        @(negedge clk);
        din       = plain(256'd7);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_handshake: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din      = '1;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat !== 5 || dout !== 256'd7 || ncorr !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d dout=%h ncorr=%0d, required 5/7/0", lat, dout, ncorr);
        end
        release_word();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        @(negedge clk);
        din      = plain(256'd123);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dout !== 256'd0 || ncorr !== 4'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_now: out_valid=%b in_ready=%b dout=%h ncorr=%0d err=%b, required 0/1/0/0/0",
                     out_valid, in_ready, dout, ncorr, err);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rstmid_noout: out_valid cycles=%0d, required 0", seen);
        end
        send_word(plain(MOD + 256'd3), lat);
        n_checks++;
        if (lat !== 6 || dout !== 256'd3 || ncorr !== 4'd1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: lat=%0d dout=%h ncorr=%0d err=%b, required 6/3/1/0", lat, dout, ncorr, err);
        end
        release_word();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
